// File: rtl/v_usampler_pkg.sv
// rtl/v_usampler_pkg.sv - state encoding and elaboration helpers for the 2x video up-sampler
package v_usampler_pkg;

   localparam logic [0:0] ST_PASS   = 1'b0;
   localparam logic [0:0] ST_REPLAY = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result = result + 1;
      return result;
   endfunction

endpackage

// File: rtl/v_usampler_linebuf.sv
// rtl/v_usampler_linebuf.sv - single-line pixel store, one write and one registered read port
module v_usampler_linebuf #(
   parameter int PIXEL_WIDTH = 24,
   parameter int ADDR_WIDTH  = 11
) (
   input  logic                   aclk,
   input  logic                   wr_en,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [PIXEL_WIDTH-1:0] wr_data,
   input  logic                   rd_en,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [PIXEL_WIDTH-1:0] rd_data
);

   logic [PIXEL_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/v_usampler_1ppc.sv
// rtl/v_usampler_1ppc.sv - 2x column/line up-sampler for 1 pixel per clock AXI4-Stream video
module v_usampler_1ppc
   import v_usampler_pkg::*;
#(
   parameter int COLUMN_UP   = 1,
   parameter int LINE_UP     = 1,
   parameter int PIXEL_WIDTH = 24,
   parameter int MAX_WIDTH   = 1920,
   parameter int ADDR_WIDTH  = 11
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   line_overflow
);

   localparam logic COL = (COLUMN_UP != 0);
   localparam logic LIN = (LINE_UP != 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_WIDTH - 1);

   if (clog2(MAX_WIDTH) > ADDR_WIDTH) begin : g_bad_addr_width
      $error("ADDR_WIDTH too small for MAX_WIDTH");
   end

   logic [0:0]             state;
   logic [ADDR_WIDTH-1:0]  wr_addr, line_last, rd_addr, eff_addr;
   logic                   wr_full, eff_full, wr_en;
   logic                   rd_vld, rd_done, rd_last;
   logic                   dup_pend, dup_last, dup_rp, m_rp_end;
   logic                   slot_free, accept, consume, fetch;
   logic [PIXEL_WIDTH-1:0] rd_data;

   assign slot_free     = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = !areset && (state == ST_PASS) && slot_free && !dup_pend;
   assign accept        = s_axis_tvalid && s_axis_tready;
   // A start-of-frame pixel always lands at address 0, discarding any partial line.
   assign eff_addr      = s_axis_tuser ? '0 : wr_addr;
   assign eff_full      = !s_axis_tuser && wr_full;
   assign wr_en         = accept && !eff_full;
   assign consume       = (state == ST_REPLAY) && rd_vld && !dup_pend && slot_free;
   // Prefetch the next pixel whenever the read register is empty or being drained.
   assign fetch         = (state == ST_REPLAY) && !rd_done && (!rd_vld || consume);

   v_usampler_linebuf #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_linebuf (
      .aclk    (aclk),
      .wr_en   (wr_en),
      .wr_addr (eff_addr),
      .wr_data (s_axis_tdata),
      .rd_en   (fetch),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= ST_PASS;
         wr_addr       <= '0;
         wr_full       <= 1'b0;
         line_last     <= '0;
         rd_addr       <= '0;
         rd_vld        <= 1'b0;
         rd_done       <= 1'b0;
         rd_last       <= 1'b0;
         dup_pend      <= 1'b0;
         dup_last      <= 1'b0;
         dup_rp        <= 1'b0;
         m_rp_end      <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         line_overflow <= 1'b0;
      end else begin
         if (slot_free) begin
            if (dup_pend) begin
               // Duplicate beat reuses the data still held in the output register.
               m_axis_tvalid <= 1'b1;
               m_axis_tuser  <= 1'b0;
               m_axis_tlast  <= dup_last;
               m_rp_end      <= dup_rp && dup_last;
               dup_pend      <= 1'b0;
            end else if (accept) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= s_axis_tdata;
               m_axis_tuser  <= s_axis_tuser;
               m_axis_tlast  <= s_axis_tlast && !COL;
               m_rp_end      <= 1'b0;
               dup_pend      <= COL;
               dup_last      <= s_axis_tlast;
               dup_rp        <= 1'b0;
            end else if (consume) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= rd_data;
               m_axis_tuser  <= 1'b0;
               m_axis_tlast  <= rd_last && !COL;
               m_rp_end      <= rd_last && !COL;
               dup_pend      <= COL;
               dup_last      <= rd_last;
               dup_rp        <= 1'b1;
            end else begin
               m_axis_tvalid <= 1'b0;
               m_rp_end      <= 1'b0;
            end
         end

         if (accept) begin
            if (eff_full) line_overflow <= 1'b1;
            if (s_axis_tlast) begin
               line_last <= eff_full ? LAST_IDX : eff_addr;
               wr_addr   <= '0;
               wr_full   <= 1'b0;
               if (LIN) begin
                  state   <= ST_REPLAY;
                  rd_addr <= '0;
                  rd_done <= 1'b0;
               end
            end else if (!eff_full) begin
               if (eff_addr == LAST_IDX) begin
                  wr_addr <= eff_addr;
                  wr_full <= 1'b1;
               end else begin
                  wr_addr <= eff_addr + ADDR_WIDTH'(1);
                  wr_full <= 1'b0;
               end
            end
         end

         if (fetch) begin
            rd_last <= (rd_addr == line_last);
            if (rd_addr == line_last) rd_done <= 1'b1;
            else                      rd_addr <= rd_addr + ADDR_WIDTH'(1);
         end
         rd_vld <= fetch || (rd_vld && !consume);

         if (state == ST_REPLAY && m_axis_tvalid && m_axis_tready && m_rp_end) state <= ST_PASS;
      end
   end

endmodule

// File: doc/v_usampler_1ppc.md
Name: v_usampler_1ppc

Overview:
- 2x video up-sampler: the neighbouring stage that restores resolution after a 2x decimating down-sampler, or sits in the reverse path.
- AXI4-Stream video in and out, 1 pixel per clock.
- Optionally repeats each pixel (column up-sampling) and each line (line up-sampling) using an internal single-line buffer.
- Regenerates clean tuser (start of frame) and tlast (end of line) for the enlarged stream.

Parameters:
- COLUMN_UP, 1, 1 = emit each input pixel twice on its line
- LINE_UP, 1, 1 = emit each input line twice (second copy replayed from the line buffer)
- PIXEL_WIDTH, 24, pixel / tdata width in bits
- MAX_WIDTH, 1920, maximum stored input pixels per line
- ADDR_WIDTH, 11, line-buffer address width; must satisfy 2^ADDR_WIDTH >= MAX_WIDTH

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  PIXEL_WIDTH  input pixel
- s_axis_tlast  in  1  end of input line
- s_axis_tuser  in  1  start of input frame
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  PIXEL_WIDTH  output pixel (registered)
- m_axis_tlast  out  1  end of output line (registered)
- m_axis_tuser  out  1  start of output frame (registered)
- line_overflow  out  1  sticky: an input line exceeded MAX_WIDTH

Behaviour:
- Reset: one clock (aclk); areset is asynchronous and active-high.
  - On reset, all m_axis_* outputs, s_axis_tready and line_overflow go to 0.
  - FSM returns to ST_PASS; write and read addresses return to 0.
  - Line-buffer contents are don't-care.
  - Reset mid-line or mid-replay abandons the line; no partial tlast is emitted.
- Output register: loads a new beat only when the slot is free, i.e. m_axis_tvalid==0 or m_axis_tready==1. While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* signals hold stable.
- Latency: an accepted input pixel appears on m_axis 1 cycle later, given the slot is free.
- ST_PASS:
  - s_axis_tready = slot free AND no pending duplicate beat.
  - An accepted pixel is written to buf[wr_addr] and wr_addr increments.
  - It is emitted with m_axis_tuser = s_axis_tuser.
  - If COLUMN_UP, the next output beat repeats the same data with tuser=0, and s_axis_tready=0 during that beat. Input throughput is 1 pixel per 2 cycles.
  - m_axis_tlast is set only on the final output beat of the line: the duplicate if COLUMN_UP, otherwise the pixel itself.
  - On accept with s_axis_tlast=1: line_len <= stored count (wr_addr+1, saturated at MAX_WIDTH); wr_addr <= 0. Go to ST_REPLAY if LINE_UP, otherwise stay in ST_PASS.
- ST_REPLAY:
  - s_axis_tready=0.
  - Reads buf[0..line_len-1]. The buffer has 1-cycle read latency, so the address is prefetched so that no bubbles occur when m_axis_tready=1.
  - Each pixel is emitted once, or twice if COLUMN_UP. tuser=0 throughout.
  - tlast is set on the final beat; its handshake returns the FSM to ST_PASS.
- Start of frame mid-line: an accepted s_axis_tuser=1 with wr_addr!=0 forces wr_addr to 0 before the write. The new line starts at that pixel; the earlier partial line is not replayed.
- Overflow: pixels at index >= MAX_WIDTH are still passed through (and duplicated) but not stored, and line_overflow is set. line_overflow is sticky until areset. Replay length is then MAX_WIDTH.
- A one-pixel line is legal. Output is 2 beats (COLUMN_UP) plus a 2-beat replay (LINE_UP).
- Both parameters 0: registered pass-through; s_axis_tready = slot free.
- Counters are ADDR_WIDTH wide with no wrap-around; overflow is handled by saturation as above.

Decomposition:
- Package v_usampler_pkg holds:
  - FSM state encoding (ST_PASS, ST_REPLAY);
  - the clog2 helper used to check ADDR_WIDTH.
- Sub-module v_usampler_linebuf: simple dual-port RAM, PIXEL_WIDTH x 2^ADDR_WIDTH.
  - One write port, one read port, both clocked on aclk.
  - Registered read (1-cycle latency); no reset on the storage.

Test Plan:
- Frame of 4x2 pixels 0x01..0x08, tuser on 0x01, both params 1, m_axis_tready=1.
  - Output is 4 lines of 8 beats: 01 01 02 02 03 03 04 04 (twice), then 05..08 the same way (twice).
  - tuser only on the first beat; tlast on every 8th beat.
- COLUMN_UP=1, LINE_UP=0, line 0xA,0xB,0xC -> A A B B C C; tlast on the last C only; s_axis_tready toggles 1,0.
- Same 4x2 frame with m_axis_tready driven by a random 50% pattern.
  - Beat sequence identical to the first test.
  - m_axis_* stable while stalled; no input beat lost or duplicated.
- Input tuser at pixel 3 of a 4-pixel line -> wr_addr restarts. The replay contains only pixels from the tuser pixel onward, and m_axis_tuser is set on that pixel's first beat.
- MAX_WIDTH=4 with a 6-pixel input line.
  - All 6 pixels are passed (12 beats).
  - Replay is the first 4 pixels (8 beats).
  - line_overflow=1 and stays 1 across later frames.
- Assert areset mid-replay -> all outputs 0 asynchronously. The next frame's output starts cleanly with tuser, with no residual replay beats.
